ex_stage_pmul: RTL and testbench

Parametrised execute stage of the 5-stage MIPS pipeline, sitting between the ID/EX and EX/MEM registers. Generalises the current EX stage in data width and register-address width, adds forwarding on store data and an `id_valid` qualifier, and adds an iterative multi-cycle multiplier (`mult`, low half) that stalls the front end via a request/hold handshake. Branch-target misprediction detection and the EX→IF feedback registers keep their existing semantics.

---
 rtl/ex_pkg.sv | 29 ++
 rtl/ex_mul_iter.sv | 71 +++++++
 rtl/ex_stage_pmul.sv | 173 +++++++++++++++++
 tb/tb_ex_stage_pmul.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_pkg.sv
// Shared encodings for the parametrised MIPS execute stage: ALU-op codes,
// R-type funct constants, forwarding-select and multiplier-state enums.
package ex_pkg;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_RTYPE = 2'b10;
  localparam logic [1:0] ALU_ADDRT = 2'b11;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_MULT = 6'b011000;

  typedef enum logic [1:0] {
    FWD_REGF = 2'd0,
    FWD_MEM  = 2'd1,
    FWD_WB   = 2'd2
  } fwd_sel_e;

  typedef enum logic [1:0] {
    MS_IDLE = 2'd0,
    MS_MUL  = 2'd1,
    MS_DONE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/ex_mul_iter.sv
// Iterative shift-add multiplier producing the low DATA_W bits of op_a*op_b
// in a fixed DATA_W iterations; no early exit for zero or sparse operands.
module ex_mul_iter
  import ex_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              EX_rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] product,
  output mul_state_e        dbg_state
);

  // Handshake: start is sampled only in IDLE, where the operands are latched.
  // busy is high for the DATA_W iteration cycles; done is a one-cycle pulse
  // during which product is final. start is ignored outside IDLE.
  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(DATA_W);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);

  mul_state_e        state, state_nxt;
  logic [DATA_W-1:0] acc, mcand, mplier;
  logic [CW-1:0]     cnt;

  always_ff @(posedge clk or negedge EX_rst_n) begin
    if (!EX_rst_n) state <= MS_IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      MS_IDLE: if (start) state_nxt = MS_MUL;
      MS_MUL:  if (cnt == CNT_LAST) state_nxt = MS_DONE;
      MS_DONE: state_nxt = MS_IDLE;
      default: state_nxt = MS_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state == MS_MUL);
    done      = (state == MS_DONE);
    product   = acc;
    dbg_state = state;
  end

  always_ff @(posedge clk or negedge EX_rst_n) begin
    if (!EX_rst_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (state == MS_IDLE && start) begin
      acc    <= '0;
      mcand  <= op_a;
      mplier <= op_b;
      cnt    <= CNT_LOAD;
    end else if (state == MS_MUL) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CNT_LAST;
    end
  end

endmodule

// File: rtl/ex_stage_pmul.sv
// Parametrised MIPS EX stage with operand/store-data forwarding, branch-target
// mispredict flush and an optional iterative mult (compiled in by EX_MUL_EN).
module ex_stage_pmul
  import ex_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              EX_rst_n,
  input  logic              id_valid,
  input  logic              id_branch,
  input  logic              id_alusrc,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_mem_to_reg,
  input  logic              id_reg_write,
  input  logic [1:0]        id_alu_op,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [DATA_W-1:0] id_rdata1,
  input  logic [DATA_W-1:0] id_rdata2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [DATA_W-1:0] id_pc,
  input  logic [1:0]        id_predictor,
  input  logic [DATA_W-1:0] id_target_pred,
  input  logic [REG_AW-1:0] mem_fwd_r,
  input  logic              mem_fwd_we,
  input  logic [DATA_W-1:0] mem_fwd_data,
  input  logic [REG_AW-1:0] wb_fwd_r,
  input  logic              wb_fwd_we,
  input  logic [DATA_W-1:0] wb_fwd_data,
  output logic              stall_req,
  output logic              flush,
  output logic [DATA_W-1:0] ex_alu_result,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [REG_AW-1:0] ex_waddr,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_mem_to_reg,
  output logic              ex_reg_write,
  output logic              ex_if_branch,
  output logic              ex_if_zero,
  output logic [DATA_W-1:0] ex_if_target,
  output logic [DATA_W-1:0] ex_if_pc,
  output logic [DATA_W-1:0] ex_if_target_pred,
  output logic [1:0]        ex_if_predictor
);

  fwd_sel_e          sel_a, sel_b;
  logic [DATA_W-1:0] op_a, fwd_b, op_b;
  logic [DATA_W-1:0] alu_res, br_target;
  logic [REG_AW-1:0] waddr;
  logic [5:0]        funct;
  logic              zero, slt_bit, issue;

  assign funct = id_imm[5:0];

  // MEM wins over WB; register 0 is never forwarded.
  always_comb begin
    sel_a = FWD_REGF;
    if (mem_fwd_we && mem_fwd_r != '0 && mem_fwd_r == id_rs)   sel_a = FWD_MEM;
    else if (wb_fwd_we && wb_fwd_r != '0 && wb_fwd_r == id_rs) sel_a = FWD_WB;
    sel_b = FWD_REGF;
    if (mem_fwd_we && mem_fwd_r != '0 && mem_fwd_r == id_rt)   sel_b = FWD_MEM;
    else if (wb_fwd_we && wb_fwd_r != '0 && wb_fwd_r == id_rt) sel_b = FWD_WB;
  end

  always_comb begin
    case (sel_a)
      FWD_MEM: op_a = mem_fwd_data;
      FWD_WB:  op_a = wb_fwd_data;
      default: op_a = id_rdata1;
    endcase
    case (sel_b)
      FWD_MEM: fwd_b = mem_fwd_data;
      FWD_WB:  fwd_b = wb_fwd_data;
      default: fwd_b = id_rdata2;
    endcase
    op_b = id_alusrc ? id_imm : fwd_b;
  end

`ifdef EX_MUL_EN
  logic              is_mult, mul_busy, mul_done;
  logic [DATA_W-1:0] mul_product;
  mul_state_e        mul_state;

  assign is_mult = id_valid && (id_alu_op == ALU_RTYPE) && (funct == FN_MULT);

  ex_mul_iter #(.DATA_W(DATA_W)) u_mul (
    .clk       (clk),
    .EX_rst_n  (EX_rst_n),
    .start     (is_mult),
    .op_a      (op_a),
    .op_b      (op_b),
    .busy      (mul_busy),
    .done      (mul_done),
    .product   (mul_product),
    .dbg_state (mul_state)
  );

  // Stall starts combinationally on the issue cycle and is released in DONE,
  // which is the cycle the held mult commits. Reset drops it at once.
  assign stall_req = EX_rst_n && (mul_busy || (is_mult && mul_state == MS_IDLE));
`else
  assign stall_req = 1'b0;
`endif

  assign slt_bit = ($signed(op_a) < $signed(op_b));

  always_comb begin
    alu_res = '0;
    case (id_alu_op)
      ALU_ADD, ALU_ADDRT: alu_res = op_a + op_b;
      ALU_SUB:            alu_res = op_a - op_b;
      default: begin
        case (funct)
          FN_ADD:  alu_res = op_a + op_b;
          FN_SUB:  alu_res = op_a - op_b;
          FN_AND:  alu_res = op_a & op_b;
          FN_OR:   alu_res = op_a | op_b;
          FN_SLT:  alu_res = {{(DATA_W-1){1'b0}}, slt_bit};
`ifdef EX_MUL_EN
          FN_MULT: alu_res = mul_done ? mul_product : '0;
`else
          FN_MULT: alu_res = '0;
`endif
          default: alu_res = '0;
        endcase
      end
    endcase
  end

  assign zero      = (alu_res == '0);
  assign waddr     = (id_alu_op == ALU_RTYPE) ? id_rd : id_rt;
  assign br_target = id_pc + (id_imm << 2);
  assign issue     = id_valid && !stall_req;
  assign flush     = EX_rst_n && issue && id_branch && zero && (id_target_pred != br_target);

  always_ff @(posedge clk or negedge EX_rst_n) begin
    if (!EX_rst_n) begin
      ex_alu_result     <= '0;
      ex_store_data     <= '0;
      ex_waddr          <= '0;
      ex_mem_read       <= 1'b0;
      ex_mem_write      <= 1'b0;
      ex_mem_to_reg     <= 1'b0;
      ex_reg_write      <= 1'b0;
      ex_if_branch      <= 1'b0;
      ex_if_zero        <= 1'b0;
      ex_if_target      <= '0;
      ex_if_pc          <= '0;
      ex_if_target_pred <= '0;
      ex_if_predictor   <= '0;
    end else begin
      ex_alu_result     <= alu_res;
      ex_store_data     <= fwd_b;
      ex_waddr          <= waddr;
      ex_mem_read       <= issue && id_mem_read;
      ex_mem_write      <= issue && id_mem_write;
      ex_mem_to_reg     <= issue && id_mem_to_reg;
      ex_reg_write      <= issue && id_reg_write;
      ex_if_branch      <= issue && id_branch;
      ex_if_zero        <= zero;
      ex_if_target      <= br_target;
      ex_if_pc          <= id_pc;
      ex_if_target_pred <= id_target_pred;
      ex_if_predictor   <= id_predictor;
    end
  end

endmodule

// File: tb/tb_ex_stage_pmul.sv
// Self-checking bench for ex_stage_pmul: directed cases plus randomized ops
// checked against an arithmetic reference model. Adapts to EX_MUL_EN.
module tb_ex_stage_pmul;

  localparam int DW = 32;
  localparam int AW = 5;
`ifdef EX_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic          clk, EX_rst_n;
  logic          id_valid, id_branch, id_alusrc, id_mem_read, id_mem_write;
  logic          id_mem_to_reg, id_reg_write;
  logic [1:0]    id_alu_op, id_predictor;
  logic [AW-1:0] id_rs, id_rt, id_rd, mem_fwd_r, wb_fwd_r;
  logic          mem_fwd_we, wb_fwd_we;
  logic [DW-1:0] id_rdata1, id_rdata2, id_imm, id_pc, id_target_pred;
  logic [DW-1:0] mem_fwd_data, wb_fwd_data;
  logic          stall_req, flush;
  logic [DW-1:0] ex_alu_result, ex_store_data, ex_if_target, ex_if_pc, ex_if_target_pred;
  logic [AW-1:0] ex_waddr;
  logic          ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write;
  logic          ex_if_branch, ex_if_zero;
  logic [1:0]    ex_if_predictor;

  ex_stage_pmul #(.DATA_W(DW), .REG_AW(AW)) dut (
    .clk(clk), .EX_rst_n(EX_rst_n), .id_valid(id_valid), .id_branch(id_branch),
    .id_alusrc(id_alusrc), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_mem_to_reg(id_mem_to_reg), .id_reg_write(id_reg_write), .id_alu_op(id_alu_op),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_rdata1(id_rdata1),
    .id_rdata2(id_rdata2), .id_imm(id_imm), .id_pc(id_pc), .id_predictor(id_predictor),
    .id_target_pred(id_target_pred), .mem_fwd_r(mem_fwd_r), .mem_fwd_we(mem_fwd_we),
    .mem_fwd_data(mem_fwd_data), .wb_fwd_r(wb_fwd_r), .wb_fwd_we(wb_fwd_we),
    .wb_fwd_data(wb_fwd_data), .stall_req(stall_req), .flush(flush),
    .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data), .ex_waddr(ex_waddr),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_reg_write(ex_reg_write), .ex_if_branch(ex_if_branch), .ex_if_zero(ex_if_zero),
    .ex_if_target(ex_if_target), .ex_if_pc(ex_if_pc), .ex_if_target_pred(ex_if_target_pred),
    .ex_if_predictor(ex_if_predictor)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  int            n_checks = 0;
  int            n_pass   = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_store, exp_target;
  logic [AW-1:0] exp_waddr;
  logic          exp_zero, exp_flush;
  logic [4:0]    exp_ctrl;
  logic          obs_flush;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [DW-1:0] fwd_val(input logic [AW-1:0] r, input logic [DW-1:0] rf);
    if (mem_fwd_we && r != 0 && mem_fwd_r == r) return mem_fwd_data;
    if (wb_fwd_we && wb_fwd_r != 0 && wb_fwd_r == r) return wb_fwd_data;
    return rf;
  endfunction

  // Reference model: what a MIPS EX stage computes for the current ID/EX slot.
  task automatic model_ex();
    logic [DW-1:0] a, rt_v, b, res;
    a    = fwd_val(id_rs, id_rdata1);
    rt_v = fwd_val(id_rt, id_rdata2);
    b    = id_alusrc ? id_imm : rt_v;
    if (id_alu_op == 2'b01) res = a - b;
    else if (id_alu_op != 2'b10) res = a + b;
    else begin
      case (id_imm[5:0])
        6'b100000: res = a + b;
        6'b100010: res = a - b;
        6'b100100: res = a & b;
        6'b100101: res = a | b;
        6'b101010: res = ($signed(a) < $signed(b)) ? 1 : 0;
        6'b011000: res = MUL_EN ? DW'(64'(a) * 64'(b)) : '0;
        default:   res = '0;
      endcase
    end
    exp_q.push_back(res);
    exp_store  = rt_v;
    exp_zero   = (res == 0);
    exp_target = id_pc + id_imm * 4;
    exp_waddr  = (id_alu_op == 2'b10) ? id_rd : id_rt;
    exp_flush  = id_valid && id_branch && exp_zero && (id_target_pred != exp_target);
    exp_ctrl   = id_valid ? {id_mem_read, id_mem_write, id_mem_to_reg, id_reg_write, id_branch} : 5'd0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic bubble_inputs();
    id_valid = 0; id_branch = 0; id_alusrc = 0; id_mem_read = 0; id_mem_write = 0;
    id_mem_to_reg = 0; id_reg_write = 0; id_alu_op = 0; id_predictor = 0;
    id_rs = 0; id_rt = 0; id_rd = 0; id_rdata1 = 0; id_rdata2 = 0; id_imm = 0;
    id_pc = 0; id_target_pred = 0; mem_fwd_r = 0; mem_fwd_we = 0; mem_fwd_data = 0;
    wb_fwd_r = 0; wb_fwd_we = 0; wb_fwd_data = 0;
  endtask

  task automatic set_op(input logic [1:0] op, input logic [5:0] fn, input logic [AW-1:0] rs,
                        input logic [AW-1:0] rt, input logic [AW-1:0] rd,
                        input logic [DW-1:0] r1, input logic [DW-1:0] r2);
    bubble_inputs();
    id_valid = 1; id_reg_write = 1; id_alu_op = op;
    id_rs = rs; id_rt = rt; id_rd = rd; id_rdata1 = r1; id_rdata2 = r2;
    id_imm = {{(DW-6){1'b0}}, fn};
  endtask

  // Called just after a rising edge; checks comb outputs, then the registered result.
  task automatic run_op();
    model_ex();
    #1;
    obs_flush = flush;
    check("stall_req", 64'(stall_req), 64'(0));
    check("flush", 64'(flush), 64'(exp_flush));
    @(posedge clk); #1;
    check("alu_result", 64'(ex_alu_result), 64'(exp_q.pop_front()));
    check("store_data", 64'(ex_store_data), 64'(exp_store));
    check("waddr", 64'(ex_waddr), 64'(exp_waddr));
    check("ctrl", 64'({ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write, ex_if_branch}),
          64'(exp_ctrl));
    check("if_zero", 64'(ex_if_zero), 64'(exp_zero));
    check("if_target", 64'(ex_if_target), 64'(exp_target));
    check("if_pc", 64'(ex_if_pc), 64'(id_pc));
    check("if_tpred", 64'(ex_if_target_pred), 64'(id_target_pred));
    check("if_pred", 64'(ex_if_predictor), 64'(id_predictor));
  endtask

`ifdef EX_MUL_EN
  task automatic run_mult(input logic [DW-1:0] a, input logic [DW-1:0] b);
    int stall_cycles;
    set_op(2'b10, 6'b011000, 1, 2, 7, a, b);
    model_ex();
    stall_cycles = 0;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (!stall_req) break;
      stall_cycles++;
      // forwarding noise after the operands are latched must not matter
      if (i == 1) begin
        mem_fwd_we = 1; mem_fwd_r = 1; mem_fwd_data = $urandom;
      end
      @(posedge clk); #1;
      check("stall_ctrl", 64'({ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write,
            ex_if_branch}), 64'(0));
    end
    check("stall_cycles", 64'(stall_cycles), 64'(DW + 1));
    @(posedge clk); #1;
    check("mult_result", 64'(ex_alu_result), 64'(exp_q.pop_front()));
    check("mult_commit", 64'(ex_reg_write), 64'(1));
    check("mult_waddr", 64'(ex_waddr), 64'(7));
    bubble_inputs();
  endtask
`endif

  // ---------------- stimulus ----------------
  initial begin
    logic [5:0] fn_tab [5];
    logic [5:0] fn;
    int         k;
    fn_tab[0] = 6'b100000; fn_tab[1] = 6'b100010; fn_tab[2] = 6'b100100;
    fn_tab[3] = 6'b100101; fn_tab[4] = 6'b101010;

    // reset with unknown inputs
    EX_rst_n = 1'b1;
    id_valid = 'x; id_branch = 'x; id_alusrc = 'x; id_mem_read = 'x; id_mem_write = 'x;
    id_mem_to_reg = 'x; id_reg_write = 'x; id_alu_op = 'x; id_predictor = 'x;
    id_rs = 'x; id_rt = 'x; id_rd = 'x; id_rdata1 = 'x; id_rdata2 = 'x; id_imm = 'x;
    id_pc = 'x; id_target_pred = 'x; mem_fwd_r = 'x; mem_fwd_we = 'x; mem_fwd_data = 'x;
    wb_fwd_r = 'x; wb_fwd_we = 'x; wb_fwd_data = 'x;
    #1 EX_rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_stall", 64'(stall_req), 64'(0));
    check("rst_flush", 64'(flush), 64'(0));
    check("rst_alu", 64'(ex_alu_result), 64'(0));
    check("rst_store", 64'(ex_store_data), 64'(0));
    check("rst_waddr", 64'(ex_waddr), 64'(0));
    check("rst_ctrl", 64'({ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write,
          ex_if_branch, ex_if_zero}), 64'(0));
    check("rst_if", 64'({ex_if_target, ex_if_pc}), 64'(0));
    check("rst_if2", 64'({ex_if_target_pred, ex_if_predictor}), 64'(0));
    bubble_inputs();
    @(posedge clk); #1;
    EX_rst_n = 1'b1;
    @(posedge clk); #1;

    // first add after reset
    set_op(2'b10, 6'b100000, 1, 2, 9, 5, 7);
    run_op();
    check("add_5_7", 64'(ex_alu_result), 64'(12));
    check("add_rd", 64'(ex_waddr), 64'(9));

    // forwarding priority
    set_op(2'b10, 6'b100000, 3, 4, 5, 32'h111, 0);
    mem_fwd_r = 3; mem_fwd_we = 1; mem_fwd_data = 32'hA;
    wb_fwd_r = 3;  wb_fwd_we = 1;  wb_fwd_data = 32'hB;
    run_op();
    check("fwd_mem_prio", 64'(ex_alu_result), 64'(32'hA));
    mem_fwd_r = 0;
    run_op();
    check("fwd_wb", 64'(ex_alu_result), 64'(32'hB));

    // store with forwarded rt
    set_op(2'b00, 6'b000000, 1, 2, 0, 32'h1000, 32'h22);
    id_alusrc = 1; id_imm = 4; id_mem_write = 1; id_reg_write = 0;
    wb_fwd_r = 2; wb_fwd_we = 1; wb_fwd_data = 32'h55;
    run_op();
    check("store_fwd", 64'(ex_store_data), 64'(32'h55));
    check("store_addr", 64'(ex_alu_result), 64'(32'h1004));
    check("store_ctrl", 64'(ex_mem_write), 64'(1));

    // branch target mispredict
    set_op(2'b01, 6'b000000, 1, 2, 0, 9, 9);
    id_reg_write = 0; id_branch = 1; id_pc = 32'h100; id_imm = 4; id_target_pred = 32'h104;
    run_op();
    check("br_flush", 64'(obs_flush), 64'(1));
    check("br_target", 64'(ex_if_target), 64'(32'h110));
    id_target_pred = 32'h110;
    run_op();
    check("br_noflush", 64'(obs_flush), 64'(0));

`ifdef EX_MUL_EN
    run_mult(32'h1234, 32'h10);
    run_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_mult(32'hDEAD_BEEF, 32'h0);
    run_mult(32'h3, 32'h8000_0000);
    for (int i = 0; i < 3; i++) run_mult($urandom, $urandom);
    @(posedge clk); #1;

    // reset pulsed mid-multiply discards the partial product
    set_op(2'b10, 6'b011000, 1, 2, 7, 32'h77, 32'h3);
    repeat (5) @(posedge clk);
    #1;
    check("mid_stall_before", 64'(stall_req), 64'(1));
    EX_rst_n = 1'b0;
    #1;
    check("mid_rst_stall", 64'(stall_req), 64'(0));
    check("mid_rst_commit", 64'(ex_reg_write), 64'(0));
    bubble_inputs();
    @(posedge clk); #1;
    EX_rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("mid_no_commit", 64'(ex_reg_write), 64'(0));
    check("mid_no_result", 64'(ex_alu_result), 64'(0));
    check("mid_idle_stall", 64'(stall_req), 64'(0));
`else
    set_op(2'b10, 6'b011000, 1, 2, 7, 32'h1234, 32'h10);
    run_op();
    check("mult_disabled", 64'(ex_alu_result), 64'(0));
`endif

    // randomized single-cycle ops
    for (int n = 0; n < 250; n++) begin
      bubble_inputs();
      k = $urandom_range(0, 6);
      if (k < 5) fn = fn_tab[k];
      else if (k == 5) fn = 6'b011000;
      else fn = 6'($urandom);
      if (MUL_EN && fn == 6'b011000) fn = 6'b100000;
      id_valid      = ($urandom_range(0, 7) != 0);
      id_alu_op     = 2'($urandom);
      id_alusrc     = 1'($urandom);
      id_branch     = 1'($urandom);
      id_mem_read   = 1'($urandom);
      id_mem_write  = 1'($urandom);
      id_mem_to_reg = 1'($urandom);
      id_reg_write  = 1'($urandom);
      id_predictor  = 2'($urandom);
      id_rs = AW'($urandom_range(0, 3));
      id_rt = AW'($urandom_range(0, 3));
      id_rd = AW'($urandom_range(0, 31));
      id_rdata1 = $urandom;
      id_rdata2 = ($urandom_range(0, 2) == 0) ? id_rdata1 : $urandom;
      id_imm = $urandom;
      id_imm[5:0] = fn;
      id_pc = $urandom;
      mem_fwd_r = AW'($urandom_range(0, 3)); mem_fwd_we = 1'($urandom);
      mem_fwd_data = ($urandom_range(0, 1) == 0) ? id_rdata1 : $urandom;
      wb_fwd_r = AW'($urandom_range(0, 3));  wb_fwd_we = 1'($urandom);
      wb_fwd_data = ($urandom_range(0, 1) == 0) ? id_rdata2 : $urandom;
      id_target_pred = ($urandom_range(0, 1) == 0) ? (id_pc + id_imm * 4) : $urandom;
      run_op();
    end

    // ---------------- final report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
